// File: rtl/boton_pkg.sv
// Shared types for the button event arbiter.
//   press_state_e : per-button press FSM encoding (IDLE / PRESS / HELD)
//   EV_SHORT/EV_LONG : values carried on ev_long
package boton_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } press_state_e;

  localparam logic EV_SHORT = 1'b0;
  localparam logic EV_LONG  = 1'b1;

endpackage : boton_pkg

// File: rtl/boton_press_fsm.sv
// Per-button press classifier: turns one debounced level into a single
// SHORT or LONG event pulse per press.
// Ports:
//   clk          system clock, posedge
//   reset        synchronous active-low reset
//   btn          debounced level, 1 = pressed
//   emit_c       combinational pulse: an event is produced at this edge
//   emit_long_c  combinational: kind of the event (EV_LONG / EV_SHORT)
module boton_press_fsm
  import boton_pkg::*;
#(
  parameter int unsigned COUNT_LONG = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic emit_c,
  output logic emit_long_c
);

  localparam int unsigned CW = $clog2(COUNT_LONG + 1);
  localparam logic [CW-1:0] CNT_LONG = CW'(COUNT_LONG);

  press_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and hold counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the event pulse is combinational so the pending slot
  // captures it on the same edge that sampled the release / N-th high cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    emit_c      = 1'b0;
    emit_long_c = EV_SHORT;
    unique case (state_q)
      ST_IDLE: begin
        if (btn) begin
          cnt_d = CW'(1);
          // Degenerate COUNT_LONG==1: first high cycle is already LONG
          if (CNT_LONG == CW'(1)) begin
            emit_c      = 1'b1;
            emit_long_c = EV_LONG;
            state_d     = ST_HELD;
          end else begin
            state_d = ST_PRESS;
          end
        end
      end
      ST_PRESS: begin
        if (btn) begin
          // Saturating increment
          if (cnt_q != CNT_LONG) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (cnt_d == CNT_LONG) begin
            emit_c      = 1'b1;
            emit_long_c = EV_LONG;
            state_d     = ST_HELD;
          end
        end else begin
          emit_c      = 1'b1;
          emit_long_c = EV_SHORT;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end
      end
      ST_HELD: begin
        if (!btn) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule : boton_press_fsm

// File: rtl/boton_event_arbiter.sv
// Button event arbiter: classifies each button's presses into SHORT/LONG
// events, holds at most one pending event per button, and presents them
// one at a time, round-robin, over a valid/ready handshake.
// Ports:
//   clk          system clock, posedge
//   reset        synchronous active-low reset
//   btn_in       debounced button levels, 1 = pressed
//   ev_valid     event available on ev_id / ev_long
//   ev_ready     consumer accepts when ev_valid && ev_ready
//   ev_id        index of the button that produced the event
//   ev_long      1 = LONG press, 0 = SHORT press
//   ev_overflow  sticky: an event was dropped (cleared only by reset)
module boton_event_arbiter
  import boton_pkg::*;
#(
  parameter int unsigned N_BOT      = 4,
  parameter int unsigned COUNT_LONG = 50_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BOT-1:0]         btn_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(N_BOT)-1:0] ev_id,
  output logic                     ev_long,
  output logic                     ev_overflow
);

  localparam int unsigned IW = $clog2(N_BOT);

  logic [N_BOT-1:0] emit_c;
  logic [N_BOT-1:0] emit_long_c;

  logic [N_BOT-1:0] pend_q, pend_d;
  logic [N_BOT-1:0] pend_long_q, pend_long_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic             ev_valid_q, ev_valid_d;
  logic [IW-1:0]    ev_id_q, ev_id_d;
  logic             ev_long_q, ev_long_d;
  logic             ev_overflow_q, ev_overflow_d;

  logic             grant_vld_c;
  logic [IW-1:0]    grant_id_c;
  logic [IW:0]      rot_idx_c;
  logic             out_free_c;
  logic             take_c;

  // One press classifier per button
  for (genvar g = 0; g < N_BOT; g++) begin : g_btn
    boton_press_fsm #(
      .COUNT_LONG (COUNT_LONG)
    ) u_press_fsm (
      .clk         (clk),
      .reset       (reset),
      .btn         (btn_in[g]),
      .emit_c      (emit_c[g]),
      .emit_long_c (emit_long_c[g])
    );
  end

  // Round-robin search: first pending slot at or after rr_q, wrapping
  always_comb begin
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    rot_idx_c   = '0;
    for (int unsigned k = 0; k < N_BOT; k++) begin
      rot_idx_c = {1'b0, rr_q} + (IW+1)'(k);
      if (rot_idx_c >= (IW+1)'(N_BOT)) begin
        rot_idx_c = rot_idx_c - (IW+1)'(N_BOT);
      end
      if (!grant_vld_c && pend_q[rot_idx_c[IW-1:0]]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = rot_idx_c[IW-1:0];
      end
    end
  end

  // Output register, pointer and pending-slot update
  always_comb begin
    pend_d        = pend_q;
    pend_long_d   = pend_long_q;
    rr_d          = rr_q;
    ev_valid_d    = ev_valid_q;
    ev_id_d       = ev_id_q;
    ev_long_d     = ev_long_q;
    ev_overflow_d = ev_overflow_q;

    // Output register can accept a new event if empty or being drained now
    out_free_c = !ev_valid_q || ev_ready;
    take_c     = out_free_c && grant_vld_c;

    if (out_free_c) begin
      ev_valid_d = grant_vld_c;
      if (grant_vld_c) begin
        ev_id_d   = grant_id_c;
        ev_long_d = pend_long_q[grant_id_c];
        rr_d      = (grant_id_c == IW'(N_BOT - 1)) ? '0 : grant_id_c + IW'(1);
      end
    end

    // A slot vacated by this cycle's grant may take a new event without loss
    for (int unsigned i = 0; i < N_BOT; i++) begin
      if (emit_c[i]) begin
        if (!pend_q[i] || (take_c && (grant_id_c == IW'(i)))) begin
          pend_d[i]      = 1'b1;
          pend_long_d[i] = emit_long_c[i];
        end else begin
          ev_overflow_d = 1'b1;
        end
      end else if (take_c && (grant_id_c == IW'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q        <= '0;
      pend_long_q   <= '0;
      rr_q          <= '0;
      ev_valid_q    <= 1'b0;
      ev_id_q       <= '0;
      ev_long_q     <= 1'b0;
      ev_overflow_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      pend_long_q   <= pend_long_d;
      rr_q          <= rr_d;
      ev_valid_q    <= ev_valid_d;
      ev_id_q       <= ev_id_d;
      ev_long_q     <= ev_long_d;
      ev_overflow_q <= ev_overflow_d;
    end
  end

  assign ev_valid    = ev_valid_q;
  assign ev_id       = ev_id_q;
  assign ev_long     = ev_long_q;
  assign ev_overflow = ev_overflow_q;

endmodule : boton_event_arbiter

// File: tb/tb_boton_event_arbiter.sv
// Directed bench for boton_event_arbiter (N_BOT=4, COUNT_LONG=8).
module tb_boton_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_id;
  logic       ev_long;
  logic       ev_overflow;

  int checks;
  int failures;

  boton_event_arbiter #(
    .N_BOT      (4),
    .COUNT_LONG (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_id       (ev_id),
    .ev_long     (ev_long),
    .ev_overflow (ev_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input logic [1:0] id, input logic lng);
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
    chk({tag, "_id"},    32'(ev_id),    32'(id));
    chk({tag, "_long"},  32'(ev_long),  32'(lng));
  endtask

  // Short press: high for 2 sampled cycles, then release is driven
  task automatic short_press(input int b);
    btn_in[b] = 1'b1;
    tick();
    tick();
    btn_in[b] = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    btn_in   = 4'b0000;
    ev_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_id",    32'(ev_id),    32'd0);
    chk("rst_long",  32'(ev_long),  32'd0);
    chk("rst_ovf",   32'(ev_overflow), 32'd0);
    reset = 1'b1;

    // 1: three-cycle press on btn 2 -> one SHORT, valid exactly one cycle
    btn_in[2] = 1'b1;
    tick(); tick(); tick();
    btn_in[2] = 1'b0;
    tick();
    chk("t1_latency", 32'(ev_valid), 32'd0);
    tick();
    chk_ev("t1_ev", 2'd2, 1'b0);
    tick();
    chk("t1_drop", 32'(ev_valid), 32'd0);

    // 2: 20-cycle hold on btn 1 -> one LONG after the 8th high cycle, nothing on release
    btn_in[1] = 1'b1;
    repeat (7) tick();
    chk("t2_7th", 32'(ev_valid), 32'd0);
    tick();
    chk("t2_8th", 32'(ev_valid), 32'd0);
    tick();
    chk_ev("t2_ev", 2'd1, 1'b1);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("t2_held", 32'(ev_valid), 32'd0);
    end
    btn_in[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_release", 32'(ev_valid), 32'd0);
    end

    // Pointer is now 2; an event on btn 3 brings it back to 0
    short_press(3);
    tick();
    tick();
    chk_ev("t3_prep0", 2'd3, 1'b0);
    tick();
    chk("t3_prep0_end", 32'(ev_valid), 32'd0);

    // 3a: simultaneous releases of 0,1,3 with pointer 0 -> 0,1,3 back to back
    btn_in = 4'b1011;
    tick(); tick();
    btn_in = 4'b0000;
    tick();
    chk("t3a_latency", 32'(ev_valid), 32'd0);
    tick();
    chk_ev("t3a_first", 2'd0, 1'b0);
    tick();
    chk_ev("t3a_second", 2'd1, 1'b0);
    tick();
    chk_ev("t3a_third", 2'd3, 1'b0);
    tick();
    chk("t3a_end", 32'(ev_valid), 32'd0);

    // Event on btn 1 moves the pointer to 2
    short_press(1);
    tick();
    tick();
    chk_ev("t3_prep2", 2'd1, 1'b0);
    tick();

    // 3b: same releases with pointer 2 -> 3,0,1
    btn_in = 4'b1011;
    tick(); tick();
    btn_in = 4'b0000;
    tick();
    tick();
    chk_ev("t3b_first", 2'd3, 1'b0);
    tick();
    chk_ev("t3b_second", 2'd0, 1'b0);
    tick();
    chk_ev("t3b_third", 2'd1, 1'b0);
    tick();
    chk("t3b_end", 32'(ev_valid), 32'd0);

    // 4: consumer stalled, three SHORT presses on btn 0 -> third dropped
    ev_ready = 1'b0;
    short_press(0);
    tick();
    tick();
    chk_ev("t4_first", 2'd0, 1'b0);
    short_press(0);
    tick();
    chk("t4_no_ovf", 32'(ev_overflow), 32'd0);
    short_press(0);
    tick();
    chk("t4_ovf", 32'(ev_overflow), 32'd1);
    chk_ev("t4_hold", 2'd0, 1'b0);
    ev_ready = 1'b1;
    tick();
    chk_ev("t4_second", 2'd0, 1'b0);
    tick();
    chk("t4_drained", 32'(ev_valid), 32'd0);
    chk("t4_ovf_sticky", 32'(ev_overflow), 32'd1);

    // 6: event held 10 cycles with ev_ready low; a press on btn 1 meanwhile waits
    ev_ready = 1'b0;
    short_press(3);
    tick();
    tick();
    chk_ev("t6_present", 2'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) btn_in[1] = 1'b1;
      if (i == 2) btn_in[1] = 1'b0;
      tick();
      chk_ev("t6_stable", 2'd3, 1'b0);
    end
    ev_ready = 1'b1;
    tick();
    chk_ev("t6_next", 2'd1, 1'b0);
    tick();
    chk("t6_end", 32'(ev_valid), 32'd0);

    // 5: reset while btn 3 is at count 5; held press restarts after reset
    btn_in[3] = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    chk("t5_rst_valid", 32'(ev_valid),    32'd0);
    chk("t5_rst_id",    32'(ev_id),       32'd0);
    chk("t5_rst_long",  32'(ev_long),     32'd0);
    chk("t5_rst_ovf",   32'(ev_overflow), 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    chk("t5_no_long", 32'(ev_valid), 32'd0);
    btn_in[3] = 1'b0;
    tick();
    chk("t5_latency", 32'(ev_valid), 32'd0);
    tick();
    chk_ev("t5_ev", 2'd3, 1'b0);
    tick();
    chk("t5_end", 32'(ev_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_boton_event_arbiter
